// File: rtl/sys_defs.sv
// Shared fetch-path types: addresses, instruction words, fetch packets, FSM states.
// Also holds the JAL opcode and J-immediate helper used by optional predecode.
package sys_defs;

    typedef logic [31:0] ADDR;
    typedef logic [31:0] INST;

    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        INST  inst;
        ADDR  pc;
        logic taken;
    } FETCH_PACKET;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    // Sign-extended J-type immediate: imm[20|10:1|11|19:12]
    function automatic logic [31:0] jal_imm(input INST i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Finds the oldest JAL among the first count lanes of a fetch bundle.
// Only instantiated when FETCH_JAL_PREDECODE_EN is defined.
module fetch_predecode
    import sys_defs::*;
#(
    parameter int FETCH_W = 4,
    parameter int PC_W    = 32,
    parameter int CW      = $clog2(FETCH_W + 1),
    parameter int LW      = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic [FETCH_W*32-1:0] bundle,
    input  logic [PC_W-1:0]       base_pc,
    input  logic [CW-1:0]         count,
    output logic                  jal_hit,
    output logic [LW-1:0]         jal_lane,
    output logic [PC_W-1:0]       jal_target
);

    INST            word;
    logic [PC_W-1:0] lane_pc;

    // Walk from the youngest lane down so the oldest match wins.
    always_comb begin
        jal_hit    = 1'b0;
        jal_lane   = '0;
        jal_target = '0;
        word       = '0;
        lane_pc    = '0;
        for (int i = FETCH_W - 1; i >= 0; i--) begin
            word    = bundle[i*32 +: 32];
            lane_pc = base_pc + PC_W'(4 * i);
            if (i < int'(count) && word[6:0] == OP_JAL) begin
                jal_hit    = 1'b1;
                jal_lane   = LW'(i);
                jal_target = lane_pc + PC_W'(jal_imm(word));
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// N-wide fetch stage: one outstanding I-cache request, credit/line clipping, redirects.
// Optional JAL predecode under FETCH_JAL_PREDECODE_EN.
module fetch_unit
    import sys_defs::*;
#(
    parameter int            FETCH_W    = 4,
    parameter int            PC_W       = 32,
    parameter int            LINE_BYTES = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int            CW         = $clog2(FETCH_W + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      icache_req_valid,
    output logic [PC_W-1:0]           icache_req_addr,
    input  logic                      icache_req_ready,
    input  logic                      icache_rsp_valid,
    input  logic [FETCH_W*32-1:0]     icache_rsp_insts,
    input  logic                      restore_valid,
    input  logic [PC_W-1:0]           restore_pc,
    input  logic [CW-1:0]             inst_buffer_spots,
    output FETCH_PACKET [FETCH_W-1:0] inst_buffer_inputs,
    output logic [CW-1:0]             instructions_valid
);

    localparam int LW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

    logic [PC_W-1:0] line_off;
    int              rem_words;
    int              clip;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_eff;
    logic [PC_W-1:0] next_pc;
    logic            deliver;
    logic            req_fire;

    always_comb begin
        line_off  = fetch_pc_q & PC_W'(LINE_BYTES - 1);
        rem_words = (LINE_BYTES - int'(line_off)) / 4;
        clip      = FETCH_W;
        if (int'(inst_buffer_spots) < clip) clip = int'(inst_buffer_spots);
        if (rem_words < clip) clip = rem_words;
        count     = CW'(clip);
    end

`ifdef FETCH_JAL_PREDECODE_EN
    logic            jal_hit;
    logic [LW-1:0]   jal_lane;
    logic [PC_W-1:0] jal_target;

    fetch_predecode #(
        .FETCH_W (FETCH_W),
        .PC_W    (PC_W),
        .CW      (CW),
        .LW      (LW)
    ) u_predecode (
        .bundle     (icache_rsp_insts),
        .base_pc    (fetch_pc_q),
        .count      (count),
        .jal_hit    (jal_hit),
        .jal_lane   (jal_lane),
        .jal_target (jal_target)
    );

    always_comb begin
        count_eff = count;
        next_pc   = fetch_pc_q + (PC_W'(count) << 2);
        if (jal_hit) begin
            count_eff = CW'(jal_lane) + CW'(1);
            next_pc   = jal_target;
        end
    end
`else
    always_comb begin
        count_eff = count;
        next_pc   = fetch_pc_q + (PC_W'(count) << 2);
    end
`endif

    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        deliver          = 1'b0;
        icache_req_valid = 1'b0;
        icache_req_addr  = fetch_pc_q;
        unique case (state_q)
            S_REQ: begin
                icache_req_valid = reset;
                if (icache_req_valid && icache_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (icache_rsp_valid) begin
                    deliver    = 1'b1;
                    fetch_pc_d = next_pc;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (icache_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
        req_fire = icache_req_valid && icache_req_ready;
        // A redirect kills any delivery and decides whether a stale response is owed.
        if (restore_valid) begin
            deliver    = 1'b0;
            fetch_pc_d = restore_pc;
            unique case (state_q)
                S_REQ:   state_d = req_fire ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = icache_rsp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = icache_rsp_valid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end
        if (!reset) deliver = 1'b0;
    end

    always_comb begin
        inst_buffer_inputs = '0;
        instructions_valid = deliver ? count_eff : '0;
        for (int i = 0; i < FETCH_W; i++) begin
            if (deliver && i < int'(count_eff)) begin
                inst_buffer_inputs[i].inst = icache_rsp_insts[i*32 +: 32];
                inst_buffer_inputs[i].pc   = ADDR'(fetch_pc_q + PC_W'(4 * i));
`ifdef FETCH_JAL_PREDECODE_EN
                inst_buffer_inputs[i].taken = jal_hit && (int'(jal_lane) == i);
`else
                inst_buffer_inputs[i].taken = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, bundles, clipping, credits, redirects, JAL.
// Inputs change 1ns after posedge; outputs sampled 2ns after posedge.
module tb_fetch_unit;
    import sys_defs::*;

    localparam int FETCH_W = 4;
    localparam int PC_W    = 32;
    localparam int CW      = 3;
    localparam logic [31:0] JAL_100 = 32'h1000006F;

    logic                      clock = 1'b0;
    logic                      reset;
    logic                      icache_req_valid;
    logic [PC_W-1:0]           icache_req_addr;
    logic                      icache_req_ready;
    logic                      icache_rsp_valid;
    logic [FETCH_W*32-1:0]     icache_rsp_insts;
    logic                      restore_valid;
    logic [PC_W-1:0]           restore_pc;
    logic [CW-1:0]             inst_buffer_spots;
    FETCH_PACKET [FETCH_W-1:0] inst_buffer_inputs;
    logic [CW-1:0]             instructions_valid;

    int passed = 0;
    int total  = 0;

    fetch_unit #(
        .FETCH_W    (FETCH_W),
        .PC_W       (PC_W),
        .LINE_BYTES (64),
        .RESET_PC   (32'h0)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .icache_req_valid   (icache_req_valid),
        .icache_req_addr    (icache_req_addr),
        .icache_req_ready   (icache_req_ready),
        .icache_rsp_valid   (icache_rsp_valid),
        .icache_rsp_insts   (icache_rsp_insts),
        .restore_valid      (restore_valid),
        .restore_pc         (restore_pc),
        .inst_buffer_spots  (inst_buffer_spots),
        .inst_buffer_inputs (inst_buffer_inputs),
        .instructions_valid (instructions_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b0;
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b0;
        icache_rsp_insts = {32'hD3, 32'hC3, 32'hB3, 32'hA3};
        restore_valid = 1'b0;
        restore_pc = '0;
        inst_buffer_spots = 3'd4;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("rst_req_valid", 64'(icache_req_valid), 64'h0);
            chk("rst_iv", 64'(instructions_valid), 64'h0);
        end
        tick(); reset = 1'b1; settle();
        chk("post_rst_req_valid", 64'(icache_req_valid), 64'h1);
        chk("post_rst_addr", 64'(icache_req_addr), 64'h0);

        // full bundle
        icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0; icache_rsp_valid = 1'b1; settle();
        chk("b0_req_valid_wait", 64'(icache_req_valid), 64'h0);
        chk("b0_iv", 64'(instructions_valid), 64'h4);
        chk("b0_pc0", 64'(inst_buffer_inputs[0].pc), 64'h0);
        chk("b0_pc1", 64'(inst_buffer_inputs[1].pc), 64'h4);
        chk("b0_pc2", 64'(inst_buffer_inputs[2].pc), 64'h8);
        chk("b0_pc3", 64'(inst_buffer_inputs[3].pc), 64'hC);
        chk("b0_inst2", 64'(inst_buffer_inputs[2].inst), 64'hC3);
        chk("b0_taken0", 64'(inst_buffer_inputs[0].taken), 64'h0);
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("b0_next_addr", 64'(icache_req_addr), 64'h10);
        chk("b0_next_valid", 64'(icache_req_valid), 64'h1);
        chk("req_idle_iv", 64'(instructions_valid), 64'h0);

        // line-boundary clip at 0x38
        restore_valid = 1'b1; restore_pc = 32'h38; settle();
        tick(); restore_valid = 1'b0; settle();
        chk("rs_req_addr", 64'(icache_req_addr), 64'h38);
        icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0; icache_rsp_valid = 1'b1; settle();
        chk("clip_iv", 64'(instructions_valid), 64'h2);
        chk("clip_pc0", 64'(inst_buffer_inputs[0].pc), 64'h38);
        chk("clip_pc1", 64'(inst_buffer_inputs[1].pc), 64'h3C);
        chk("clip_lane2_zero", 64'(inst_buffer_inputs[2]), 64'h0);
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("clip_next_addr", 64'(icache_req_addr), 64'h40);

        // credit clip: spots=1 then spots=0
        inst_buffer_spots = 3'd1; icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0; icache_rsp_valid = 1'b1; settle();
        chk("sp1_iv", 64'(instructions_valid), 64'h1);
        chk("sp1_pc0", 64'(inst_buffer_inputs[0].pc), 64'h40);
        chk("sp1_lane1_zero", 64'(inst_buffer_inputs[1]), 64'h0);
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("sp1_next_addr", 64'(icache_req_addr), 64'h44);
        inst_buffer_spots = 3'd0; icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0; icache_rsp_valid = 1'b1; settle();
        chk("sp0_iv", 64'(instructions_valid), 64'h0);
        tick(); icache_rsp_valid = 1'b0; inst_buffer_spots = 3'd4; settle();
        chk("sp0_same_addr", 64'(icache_req_addr), 64'h44);
        chk("sp0_req_valid", 64'(icache_req_valid), 64'h1);

        // restore in WAIT, response 2 cycles later
        icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0;
        restore_valid = 1'b1; restore_pc = 32'h200; settle();
        chk("rw_iv", 64'(instructions_valid), 64'h0);
        tick(); restore_valid = 1'b0; settle();
        chk("drain_req_valid", 64'(icache_req_valid), 64'h0);
        tick(); icache_rsp_valid = 1'b1; settle();
        chk("drain_discard_iv", 64'(instructions_valid), 64'h0);
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("rw_next_addr", 64'(icache_req_addr), 64'h200);
        chk("rw_next_valid", 64'(icache_req_valid), 64'h1);

        // restore and response in the same cycle
        icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b1; restore_valid = 1'b1; restore_pc = 32'h280; settle();
        chk("rr_same_iv", 64'(instructions_valid), 64'h0);
        tick(); icache_rsp_valid = 1'b0; restore_valid = 1'b0; settle();
        chk("rr_same_addr", 64'(icache_req_addr), 64'h280);
        chk("rr_same_valid", 64'(icache_req_valid), 64'h1);

        // restore coinciding with handshake
        icache_req_ready = 1'b1; restore_valid = 1'b1; restore_pc = 32'h400; settle();
        tick(); icache_req_ready = 1'b0; restore_valid = 1'b0; settle();
        chk("rh_drain_req_valid", 64'(icache_req_valid), 64'h0);
        icache_rsp_valid = 1'b1; settle();
        chk("rh_discard_iv", 64'(instructions_valid), 64'h0);
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("rh_next_addr", 64'(icache_req_addr), 64'h400);

        // JAL +0x100 in lane 1 (PC 0x4)
        restore_valid = 1'b1; restore_pc = 32'h0; settle();
        tick(); restore_valid = 1'b0; icache_req_ready = 1'b1; settle();
        tick(); icache_req_ready = 1'b0; icache_rsp_valid = 1'b1;
        icache_rsp_insts = {32'h13, 32'h13, JAL_100, 32'h13}; settle();
`ifdef FETCH_JAL_PREDECODE_EN
        chk("jal_iv", 64'(instructions_valid), 64'h2);
        chk("jal_taken1", 64'(inst_buffer_inputs[1].taken), 64'h1);
        chk("jal_taken0", 64'(inst_buffer_inputs[0].taken), 64'h0);
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("jal_next_addr", 64'(icache_req_addr), 64'h104);
`else
        chk("jal_iv", 64'(instructions_valid), 64'h4);
        chk("jal_taken1", 64'(inst_buffer_inputs[1].taken), 64'h0);
        chk("jal_inst1", 64'(inst_buffer_inputs[1].inst), 64'(JAL_100));
        tick(); icache_rsp_valid = 1'b0; settle();
        chk("jal_next_addr", 64'(icache_req_addr), 64'h10);
`endif

        // reset mid-WAIT
        icache_req_ready = 1'b1;
        tick(); icache_req_ready = 1'b0; reset = 1'b0; settle();
        chk("rst_wait_iv", 64'(instructions_valid), 64'h0);
        tick(); reset = 1'b1; settle();
        chk("rst_wait_addr", 64'(icache_req_addr), 64'h0);
        chk("rst_wait_valid", 64'(icache_req_valid), 64'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
